// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the serial add/subtract block.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAdd  = 2'b01,
    StDone = 2'b10
  } state_e;

  function automatic int unsigned calc_steps(int unsigned width, int unsigned digit);
    return width / digit;
  endfunction

  // Counter is at least one bit wide even when a single step covers the word.
  function automatic int unsigned calc_cnt_w(int unsigned steps);
    return (steps > 1) ? int'($clog2(steps)) : 1;
  endfunction

endpackage

// File: rtl/serial_digit_add.sv
// Combinational DIGIT-bit ripple adder; also reports the carry into its top bit.
module serial_digit_add #(
  parameter int unsigned Digit = 1
) (
  input  logic [Digit-1:0] a_i,
  input  logic [Digit-1:0] b_i,
  input  logic             cin_i,
  output logic [Digit-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic c;

  always_comb begin
    c      = cin_i;
    cmsb_o = 1'b0;
    sum_o  = '0;
    for (int i = 0; i < int'(Digit); i++) begin
      if (i == int'(Digit) - 1) cmsb_o = c;
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (a_i[i] & c) | (b_i[i] & c);
    end
    cout_o = c;
  end

endmodule

// File: rtl/serial_addsub_fsm.sv
// Digit-serial add/subtract with valid/ready handshakes on both sides.
// Define SERIAL_ADDSUB_OVF_EN to compute the signed-overflow flag; otherwise ovf is tied low.
module serial_addsub_fsm
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned Steps = calc_steps(WIDTH, DIGIT);
  localparam int unsigned CntW  = calc_cnt_w(Steps);
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic [CntW-1:0]   cnt_q;
  logic              carry_q, cout_q, out_valid_q, busy_q, in_ready_q;

  logic [31:0]       off;
  logic [DIGIT-1:0]  dig_a, dig_b, dig_sum;
  logic [WIDTH-1:0]  sum_ins;
  logic              dig_cout, dig_cmsb;

  always_comb begin
    off     = 32'(cnt_q) * DIGIT;
    dig_a   = DIGIT'(a_q >> off);
    dig_b   = DIGIT'(b_q >> off);
    sum_ins = WIDTH'(dig_sum) << off;
  end

  serial_digit_add #(
    .Digit (DIGIT)
  ) u_digit_add (
    .a_i    (dig_a),
    .b_i    (dig_b),
    .cin_i  (carry_q),
    .sum_o  (dig_sum),
    .cout_o (dig_cout),
    .cmsb_o (dig_cmsb)
  );

`ifdef SERIAL_ADDSUB_OVF_EN
  logic cmsb_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmsb_q <= 1'b0;
    end else if (state_q == StIdle && in_valid && in_ready_q) begin
      cmsb_q <= 1'b0;
    end else if (state_q == StAdd && cnt_q == LastCnt) begin
      cmsb_q <= dig_cmsb;
    end
  end
  assign ovf = cmsb_q ^ cout_q;
`else
  logic unused_cmsb;
  assign unused_cmsb = dig_cmsb;
  assign ovf         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            carry_q    <= sub;
            sum_q      <= '0;
            cnt_q      <= '0;
            cout_q     <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StAdd;
          end
        end
        StAdd: begin
          sum_q   <= sum_q | sum_ins;
          carry_q <= dig_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            cout_q      <= dig_cout;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q & rst_n;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_addsub_fsm.sv
// Directed bench for serial_addsub_fsm: an 8-bit/1-bit-digit instance and an 8-bit/4-bit one.
module tb_serial_addsub_fsm;

`ifdef SERIAL_ADDSUB_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, busy;
  logic [7:0] a, b, sum;
  logic       in_valid4, in_ready4, sub4, out_valid4, out_ready4, cout4, ovf4, busy4;
  logic [7:0] a4, b4, sum4;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_addsub_fsm #(.WIDTH(8), .DIGIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .ovf(ovf), .busy(busy)
  );

  serial_addsub_fsm #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4),
    .ovf(ovf4), .busy(busy4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation for a single edge, then counts edges until out_valid.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                          output int lat);
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_total++;
    if ({in_ready, out_valid, busy, sum, cout, ovf} !== 13'b0)
      $display("FAIL reset_outputs: got %b want %b", {in_ready, out_valid, busy, sum, cout, ovf}, 13'b0);
    else n_pass++;
    rst_n = 1'b1;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL reset_release_ready: got %b want 0", in_ready);
    else n_pass++;
    step();
    n_total++;
    if ({in_ready, in_ready4} !== 2'b11)
      $display("FAIL reset_first_edge_ready: got %b want 11", {in_ready, in_ready4});
    else n_pass++;
  endtask

  task automatic test_add();
    int lat;
    start_op(8'h3C, 8'h0F, 1'b0, lat);
    n_total++;
    if (lat !== 8) $display("FAIL add_latency: got %0d want 8", lat);
    else n_pass++;
    n_total++;
    if ({sum, cout, ovf, busy, in_ready} !== {8'h4B, 1'b0, 1'b0, 1'b1, 1'b0})
      $display("FAIL add_3c_0f: got sum=%h cout=%b ovf=%b busy=%b rdy=%b want 4b 0 0 1 0",
               sum, cout, ovf, busy, in_ready);
    else n_pass++;
    handshake();
    n_total++;
    if ({out_valid, busy, in_ready} !== 3'b001)
      $display("FAIL add_release: got v/busy/rdy=%b want 001", {out_valid, busy, in_ready});
    else n_pass++;
  endtask

  task automatic test_sub();
    int lat;
    start_op(8'h05, 8'h07, 1'b1, lat);
    n_total++;
    if ({sum, cout, ovf} !== {8'hFE, 1'b0, 1'b0})
      $display("FAIL sub_05_07: got sum=%h cout=%b ovf=%b want fe 0 0", sum, cout, ovf);
    else n_pass++;
    handshake();
    start_op(8'h80, 8'h01, 1'b1, lat);
    n_total++;
    if ({sum, cout, ovf} !== {8'h7F, 1'b1, OvfEn})
      $display("FAIL sub_80_01: got sum=%h cout=%b ovf=%b want 7f 1 %b", sum, cout, ovf, OvfEn);
    else n_pass++;
    handshake();
  endtask

  task automatic test_hold();
    int lat;
    int bad = 0;
    start_op(8'h7F, 8'h01, 1'b0, lat);
    n_total++;
    if ({sum, cout, ovf} !== {8'h80, 1'b0, OvfEn})
      $display("FAIL hold_result: got sum=%h cout=%b ovf=%b want 80 0 %b", sum, cout, ovf, OvfEn);
    else n_pass++;
    // A competing request while the result waits must be ignored.
    in_valid = 1'b1; a = 8'h11; b = 8'h22; sub = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, 8'h80, 1'b0, OvfEn}) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
    else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_total++;
    if ({out_valid, in_ready, busy} !== 3'b010)
      $display("FAIL hold_release: got v/rdy/busy=%b want 010", {out_valid, in_ready, busy});
    else n_pass++;
    step();
    in_valid = 1'b0;
    n_total++;
    if ({busy, in_ready} !== 2'b10)
      $display("FAIL hold_next_accept: got busy/rdy=%b want 10", {busy, in_ready});
    else n_pass++;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    n_total++;
    if (sum !== 8'hEF) $display("FAIL hold_second_op: got %h want ef", sum);
    else n_pass++;
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat;
    a = 8'h55; b = 8'h11; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    n_total++;
    if ({in_ready, out_valid, busy, sum, cout, ovf} !== 13'b0)
      $display("FAIL midreset_outputs: got %b want %b", {in_ready, out_valid, busy, sum, cout, ovf}, 13'b0);
    else n_pass++;
    rst_n = 1'b1;
    step();
    start_op(8'h01, 8'h01, 1'b0, lat);
    n_total++;
    if ({lat, sum, cout} !== {32'd8, 8'h02, 1'b0})
      $display("FAIL midreset_new_op: got lat=%0d sum=%h cout=%b want 8 02 0", lat, sum, cout);
    else n_pass++;
    handshake();
  endtask

  task automatic test_digit4();
    int lat;
    a4 = 8'hFF; b4 = 8'h01; sub4 = 1'b0; in_valid4 = 1'b1;
    step();
    in_valid4 = 1'b0;
    lat = 0;
    while (out_valid4 !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    n_total++;
    if (lat !== 2) $display("FAIL digit4_latency: got %0d want 2", lat);
    else n_pass++;
    n_total++;
    if ({sum4, cout4, ovf4} !== {8'h00, 1'b1, 1'b0})
      $display("FAIL digit4_ff_01: got sum=%h cout=%b ovf=%b want 00 1 0", sum4, cout4, ovf4);
    else n_pass++;
  endtask

  initial begin
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0; out_ready4 = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_hold();
    test_reset_mid();
    test_digit4();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
